// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
//
// Owns the HI/LO register pair next to the execute-stage ALU. It runs
// MULT/MULTU/DIV/DIVU as a 32-step radix-2 datapath: shift-add for multiply
// and restoring division for divide. It also serves MTHI/MTLO/MFHI/MFLO.
// A HI/LO request that arrives while an operation is in flight raises stall.
// The requester then holds the request until stall drops.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation in flight
//   start  op/a/b valid this cycle
//   op     7-bit operation code, shared with the ALU encoding
//   a      rs operand: dividend, multiplicand, or MTHI/MTLO data
//   b      rt operand: divisor or multiplier
//   busy   multiply/divide in flight
//   stall  request must be held and re-presented
//   done   one-cycle pulse after HI/LO are written by a multiply/divide
//   r      MFHI/MFLO read data, zero when no MF op is presented
//   hi     HI register
//   lo     LO register
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MFHI  = 7'd9;
  localparam logic [6:0] OP_MFLO  = 7'd10;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_t;

  state_t state, state_next;

  logic [4:0]         counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               mode_mul;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               is_mul;
  logic               is_div;
  logic               is_signed;
  logic               is_hilo;
  logic               accept;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operation decode and the operand magnitudes that are latched at accept.
  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_hilo   = (op >= OP_DIV) && (op <= OP_MULTU);
    accept    = start && (state == IDLE) && (is_mul || is_div);
    abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration step. acc is shared by both operations.
  // Multiply: acc holds {partial product, unconsumed multiplier bits}.
  // Divide: acc holds {partial remainder, dividend bits becoming quotient}.
  // The partial remainder stays below the divisor, so the restored or
  // subtracted remainder always fits in WIDTH bits.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand});
    div_diff  = div_shift[WIDTH-1:0] - operand;
  end

  // Sign correction applied in FIXUP. A zero divisor forces an all-ones
  // quotient. The remainder then equals |a|, and restoring its sign gives
  // back the original dividend.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = div_zero ? {WIDTH{1'b1}} :
               (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. MF reads are served only in IDLE.
  // An MF read presented while busy is stalled instead.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    stall      = 1'b0;
    r          = '0;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (counter == 5'd31) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      stall = start && busy && is_hilo;
      if (start && !busy) begin
        if (op == OP_MFHI) begin
          r = hi;
        end else if (op == OP_MFLO) begin
          r = lo;
        end
      end
    end
  end

  // Datapath, HI/LO and done. MT writes only land in IDLE, so they can
  // never collide with the FIXUP write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      counter  <= '0;
      acc      <= '0;
      operand  <= '0;
      mode_mul <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_mul <= is_mul;
            neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= is_signed && is_div && a[WIDTH-1];
            div_zero <= is_div && (b == '0);
            operand  <= is_mul ? abs_a : abs_b;
            acc      <= {{WIDTH{1'b0}}, (is_mul ? abs_b : abs_a)};
            counter  <= '0;
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        RUN: begin
          if (mode_mul) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else if (div_ge) begin
            acc <= {div_diff, acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
          counter <= counter + 5'd1;
        end
        FIXUP: begin
          if (mode_mul) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer
//
// Self-checking bench for hilo_muldiv_sequencer. It runs a table of fixed
// multiply/divide vectors, then randomized operations checked against a
// plain-arithmetic reference model. Hand-written sequences cover HI/LO
// moves, stalling during a run and reset mid-operation.
module tb_hilo_muldiv_sequencer;

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MFHI  = 7'd9;
  localparam logic [6:0] OP_MFLO  = 7'd10;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] r;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  vec_t        vecs[$];
  logic [31:0] got_hi;
  logic [31:0] got_lo;
  int          busy_cycles;
  int          done_pulses;
  int          unstalled;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .r     (r),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model: the result is {hi, lo} from ordinary 64-bit arithmetic.
  // Signed division in SV truncates toward zero, and % takes the dividend's
  // sign, which is the required HI/LO behaviour.
  function automatic logic [63:0] refResult(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      rm;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    if (o == OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
    end else if (o == OP_MULT) begin
      p = sx * sy;
    end else if (y == 32'd0) begin
      p = {x, 32'hFFFFFFFF};
    end else if (o == OP_DIVU) begin
      p = {x % y, x / y};
    end else begin
      q  = sx / sy;
      rm = sx % sy;
      p  = {rm[31:0], q[31:0]};
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one multiply/divide for a single cycle. It then scrambles a/b
  // and watches 40 cycles, recording busy duration, done pulses and the
  // HI/LO values seen in the done cycle.
  task automatic applyStimulus(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] rhi, output logic [31:0] rlo,
                               output int nbusy, output int ndone);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 7'd0;
    a     = $urandom;
    b     = $urandom;
    nbusy = 0;
    ndone = 0;
    rhi   = 'x;
    rlo   = 'x;
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        rhi = hi;
        rlo = lo;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 7'd0;
    a     = '0;
    b     = '0;

    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"});
    vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"});
    vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"});
    vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2"});
    vecs.push_back('{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu_by0"});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, "div_neg_by0"});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",  {31'b0, busy},  32'd0);
    checkOutput("reset_done",  {31'b0, done},  32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_hi",    hi, 32'd0);
    checkOutput("reset_lo",    lo, 32'd0);
    checkOutput("reset_r",     r,  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // HI/LO moves, combinational MF reads and an ignored op code.
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'hA5A50001;
    @(negedge clk);
    op = OP_MTLO;
    a  = 32'h0000BEEF;
    @(negedge clk);
    op = OP_MFHI;
    a  = 32'h0;
    #1;
    checkOutput("mfhi_r",    r, 32'hA5A50001);
    checkOutput("mt_nobusy", {31'b0, busy}, 32'd0);
    op = OP_MFLO;
    #1;
    checkOutput("mflo_r", r, 32'h0000BEEF);
    op = 7'd3;
    #1;
    checkOutput("other_r",     r, 32'd0);
    checkOutput("other_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("other_busy", {31'b0, busy}, 32'd0);
    checkOutput("other_hi",   hi, 32'hA5A50001);
    start = 1'b0;

    // Fixed vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, got_hi, got_lo, busy_cycles, done_pulses);
      checkOutput({vecs[i].name, "_hi"},    got_hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo"},    got_lo, vecs[i].exp_lo);
      checkOutput({vecs[i].name, "_busy"},  32'(busy_cycles), 32'd33);
      checkOutput({vecs[i].name, "_done"},  32'(done_pulses), 32'd1);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [6:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] exp;
      case ($urandom_range(0, 3))
        0:       ro = OP_MULT;
        1:       ro = OP_MULTU;
        2:       ro = OP_DIV;
        default: ro = OP_DIVU;
      endcase
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      exp = refResult(ro, ra, rb);
      applyStimulus(ro, ra, rb, got_hi, got_lo, busy_cycles, done_pulses);
      checkOutput($sformatf("rand%0d_hi", i),   got_hi, exp[63:32]);
      checkOutput($sformatf("rand%0d_lo", i),   got_lo, exp[31:0]);
      checkOutput($sformatf("rand%0d_busy", i), 32'(busy_cycles), 32'd33);
    end

    // Stalled MTHI/MFLO during a MULTU 6*7.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h0BADF00D;
    @(negedge clk);
    op = OP_MULTU;
    a  = 32'd6;
    b  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h00000055;
    #1;
    checkOutput("mthi_run_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("mthi_run_hi", hi, 32'h0BADF00D);
    @(negedge clk);
    op = OP_MFLO;
    a  = 32'd0;
    unstalled = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
      if (!stall) unstalled++;
    end
    checkOutput("stall_held",    32'(unstalled), 32'd0);
    checkOutput("stall_done",    {31'b0, done},  32'd1);
    checkOutput("stall_release", {31'b0, stall}, 32'd0);
    checkOutput("stall_mflo_r",  r,  32'd42);
    checkOutput("stall_hi",      hi, 32'd0);
    @(negedge clk);
    start = 1'b0;

    // Reset during the 10th RUN cycle of a MULT aborts with no done pulse.
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h00001111;
    @(negedge clk);
    op = OP_MTLO;
    a  = 32'h00002222;
    @(negedge clk);
    op = OP_MULT;
    a  = 32'd5;
    b  = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("abort_pre_hi", hi, 32'h00001111);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_hi",   hi, 32'd0);
    checkOutput("abort_lo",   lo, 32'd0);
    done_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_pulses++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_nodone", 32'(done_pulses), 32'd0);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    op = OP_MFHI;
    a  = 32'd0;
    #1;
    checkOutput("abort_mfhi_r", r, 32'hDEADBEEF);
    @(negedge clk);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
